// File: rtl/bft_leaf_endpoint.sv
// Leaf endpoint of the BFT packet bus: a TX FIFO feeds a rate-limited injection FSM,
// and an RX address filter feeds an RX FIFO with drop and misroute counters.
module bft_leaf_endpoint #(
    parameter  int num_leaves = 2,
    parameter  int payload_sz = 1,
    parameter  int addr       = 0,
    parameter  int fifo_depth = 4,
    parameter  int inject_gap = 0,
    localparam int DEST_W     = $clog2(num_leaves),
    localparam int p_sz       = 1 + DEST_W + payload_sz
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [p_sz-1:0]       bus_o,
    input  logic [p_sz-1:0]       bus_i,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    input  logic [DEST_W-1:0]     tx_dest,
    input  logic [payload_sz-1:0] tx_payload,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic [payload_sz-1:0] rx_payload,
    output logic [15:0]           drop_cnt,
    output logic [15:0]           misroute_cnt
);

    localparam int PTR_W = $clog2(fifo_depth);
    localparam int TX_W  = DEST_W + payload_sz;
    localparam int GAP_W = (inject_gap > 1) ? $clog2(inject_gap) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP} state_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [TX_W-1:0]       r_tx_mem [fifo_depth];
    logic [PTR_W:0]        r_tx_wr, r_tx_rd;
    logic [payload_sz-1:0] r_rx_mem [fifo_depth];
    logic [PTR_W:0]        r_rx_wr, r_rx_rd;
    logic [p_sz-1:0]       r_bus;
    state_t                r_state;
    logic [GAP_W-1:0]      r_gap_cnt;
    logic [15:0]           r_drop_cnt, r_mis_cnt;

    logic                  w_tx_empty, w_tx_full, w_tx_push, w_tx_pop, w_launch;
    state_t                w_state_nxt;
    logic [GAP_W-1:0]      w_gap_nxt;
    logic [p_sz-1:0]       w_bus_nxt;
    logic                  w_rx_vld, w_rx_hit, w_rx_empty, w_rx_full;
    logic                  w_rx_push, w_rx_pop, w_rx_drop, w_rx_mis;
    logic [DEST_W-1:0]     w_rx_dest;

    // Full/empty from an extra wrap bit on each pointer.
    assign w_tx_empty = (r_tx_wr == r_tx_rd);
    assign w_tx_full  = (r_tx_wr[PTR_W] != r_tx_rd[PTR_W]) &&
                        (r_tx_wr[PTR_W-1:0] == r_tx_rd[PTR_W-1:0]);
    assign tx_ready   = reset & ~w_tx_full;
    assign w_tx_push  = tx_valid & tx_ready;

    always_ff @(posedge clk) begin
        if (w_tx_push) r_tx_mem[r_tx_wr[PTR_W-1:0]] <= {tx_dest, tx_payload};
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gap_nxt   = r_gap_cnt;
        w_bus_nxt   = '0;
        w_tx_pop    = 1'b0;
        w_launch    = 1'b0;
        case (r_state)
            ST_IDLE: w_launch = ~w_tx_empty;
            ST_SEND: begin
                if (inject_gap == 0) begin
                    w_launch    = ~w_tx_empty;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_gap_nxt   = GAP_W'(inject_gap - 1);
                    w_state_nxt = ST_GAP;
                end
            end
            ST_GAP: begin
                // Last idle cycle may launch directly so the gap is exactly inject_gap cycles.
                if (r_gap_cnt == '0) begin
                    w_launch    = ~w_tx_empty;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_gap_nxt = r_gap_cnt - 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (w_launch) begin
            w_tx_pop    = 1'b1;
            w_bus_nxt   = {1'b1, r_tx_mem[r_tx_rd[PTR_W-1:0]]};
            w_state_nxt = ST_SEND;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tx_wr   <= '0;
            r_tx_rd   <= '0;
            r_state   <= ST_IDLE;
            r_gap_cnt <= '0;
            r_bus     <= '0;
        end else begin
            if (w_tx_push) r_tx_wr <= r_tx_wr + 1'b1;
            if (w_tx_pop)  r_tx_rd <= r_tx_rd + 1'b1;
            r_state   <= w_state_nxt;
            r_gap_cnt <= w_gap_nxt;
            r_bus     <= w_bus_nxt;
        end
    end

    assign bus_o = r_bus;

    assign w_rx_vld   = bus_i[p_sz-1];
    assign w_rx_dest  = bus_i[p_sz-2 -: DEST_W];
    assign w_rx_hit   = w_rx_vld && (w_rx_dest == DEST_W'(addr));
    assign w_rx_mis   = w_rx_vld && (w_rx_dest != DEST_W'(addr));
    assign w_rx_empty = (r_rx_wr == r_rx_rd);
    assign w_rx_full  = (r_rx_wr[PTR_W] != r_rx_rd[PTR_W]) &&
                        (r_rx_wr[PTR_W-1:0] == r_rx_rd[PTR_W-1:0]);
    assign rx_valid   = ~w_rx_empty;
    assign w_rx_pop   = rx_valid & rx_ready;
    // A pop in the same cycle frees the slot the push lands in.
    assign w_rx_push  = w_rx_hit & (~w_rx_full | w_rx_pop);
    assign w_rx_drop  = w_rx_hit & w_rx_full & ~w_rx_pop;
    assign rx_payload = r_rx_mem[r_rx_rd[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (w_rx_push) r_rx_mem[r_rx_wr[PTR_W-1:0]] <= bus_i[payload_sz-1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_wr    <= '0;
            r_rx_rd    <= '0;
            r_drop_cnt <= '0;
            r_mis_cnt  <= '0;
        end else begin
            if (w_rx_push) r_rx_wr <= r_rx_wr + 1'b1;
            if (w_rx_pop)  r_rx_rd <= r_rx_rd + 1'b1;
            if (w_rx_drop) r_drop_cnt <= sat_inc(r_drop_cnt);
            if (w_rx_mis)  r_mis_cnt  <= sat_inc(r_mis_cnt);
        end
    end

    assign drop_cnt     = r_drop_cnt;
    assign misroute_cnt = r_mis_cnt;

endmodule
